// File: rtl/sram_seq_ctrl.sv
// Burst sequencer driving the shared port of the 256x64 SRAM macro wrapper.
// Write bursts stream words into the SRAM; read bursts stream words back through a small credit-limited FIFO.
module sram_seq_ctrl #(
   parameter int ADDR_W    = 8,
   parameter int DATA_W    = 64,
   parameter int LEN_W     = 9,
   parameter int OUT_DEPTH = 2
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic              cmd_write_i,
   input  logic [ADDR_W-1:0] cmd_addr_i,
   input  logic [LEN_W-1:0]  cmd_len_i,
   input  logic              wr_valid_i,
   output logic              wr_ready_o,
   input  logic [DATA_W-1:0] wr_data_i,
   output logic              rd_valid_o,
   input  logic              rd_ready_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic              rd_last_o,
   output logic              busy_o,
   output logic              done_o,
   output logic [ADDR_W-1:0] sram_addr_o,
   output logic [DATA_W-1:0] sram_wr_data_o,
   output logic              sram_en_o,
   output logic              sram_rw_mode_o,
   input  logic [DATA_W-1:0] sram_rd_data_i
);

   localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
   localparam int CNT_W = $clog2(OUT_DEPTH + 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WRITE = 2'd1,
      S_READ  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   w_addr_nxt;
   logic [LEN_W-1:0]    r_issue_rem;
   logic [LEN_W-1:0]    w_issue_rem_nxt;
   logic [LEN_W-1:0]    r_ret_rem;
   logic [LEN_W-1:0]    w_ret_rem_nxt;
   logic                r_inflight;
   logic                w_issue;
   logic                w_sram_en;
   logic                w_sram_rw;
   logic [DATA_W-1:0]   w_sram_wr_data;
   logic                w_wr_ready;

   logic [DATA_W-1:0]   r_fifo_mem [OUT_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;
   logic                w_rd_valid;
   logic                w_pop;
   logic [CNT_W:0]      w_occ;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(OUT_DEPTH - 1)) ? PTR_W'(0) : p + PTR_W'(1);
   endfunction

   assign w_rd_valid = (r_count != CNT_W'(0));
   assign w_pop      = w_rd_valid & rd_ready_i;
   // Words already owed to the FIFO this cycle; a slot freed by a pop can be re-issued at once.
   assign w_occ      = {1'b0, r_count} + {{CNT_W{1'b0}}, r_inflight} - {{CNT_W{1'b0}}, w_pop};

   // State, address and burst counters
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state     <= S_IDLE;
         r_addr      <= '0;
         r_issue_rem <= '0;
         r_ret_rem   <= '0;
         r_inflight  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_addr      <= w_addr_nxt;
         r_issue_rem <= w_issue_rem_nxt;
         r_ret_rem   <= w_ret_rem_nxt;
         r_inflight  <= w_issue;
      end
   end

   // Next-state, counter updates and SRAM port drive
   always_comb begin
      w_state_nxt     = r_state;
      w_addr_nxt      = r_addr;
      w_issue_rem_nxt = r_issue_rem;
      w_ret_rem_nxt   = r_ret_rem;
      w_issue         = 1'b0;
      w_sram_en       = 1'b0;
      w_sram_rw       = 1'b0;
      w_sram_wr_data  = '0;
      w_wr_ready      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (cmd_valid_i) begin
               w_addr_nxt      = cmd_addr_i;
               w_issue_rem_nxt = cmd_len_i;
               w_ret_rem_nxt   = cmd_len_i;
               if (cmd_len_i == LEN_W'(0)) begin
                  w_state_nxt = S_DONE;
               end else if (cmd_write_i) begin
                  w_state_nxt = S_WRITE;
               end else begin
                  w_state_nxt = S_READ;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_WRITE: begin
            w_wr_ready     = 1'b1;
            w_sram_rw      = 1'b1;
            w_sram_wr_data = wr_data_i;
            w_sram_en      = wr_valid_i;
            if (wr_valid_i) begin
               w_addr_nxt      = r_addr + ADDR_W'(1);
               w_issue_rem_nxt = r_issue_rem - LEN_W'(1);
               if (r_issue_rem == LEN_W'(1)) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_WRITE;
               end
            end else begin
               w_state_nxt = S_WRITE;
            end
         end
         S_READ: begin
            if ((r_issue_rem != LEN_W'(0)) && (w_occ < (CNT_W + 1)'(OUT_DEPTH))) begin
               w_issue         = 1'b1;
               w_sram_en       = 1'b1;
               w_addr_nxt      = r_addr + ADDR_W'(1);
               w_issue_rem_nxt = r_issue_rem - LEN_W'(1);
            end else begin
               w_issue = 1'b0;
            end
            if (w_pop) begin
               w_ret_rem_nxt = r_ret_rem - LEN_W'(1);
               if (r_ret_rem == LEN_W'(1)) begin
                  w_state_nxt = S_DONE;
               end else begin
                  w_state_nxt = S_READ;
               end
            end else begin
               w_state_nxt = S_READ;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // Read-return FIFO: push lands one cycle after each issue
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < OUT_DEPTH; i++) begin
            r_fifo_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (r_inflight) begin
            r_fifo_mem[r_wr_ptr] <= sram_rd_data_i;
            r_wr_ptr             <= ptr_inc(r_wr_ptr);
         end
         if (w_pop) begin
            r_rd_ptr <= ptr_inc(r_rd_ptr);
         end
         case ({r_inflight, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign cmd_ready_o    = (r_state == S_IDLE) & rst_i;
   assign wr_ready_o     = w_wr_ready;
   assign rd_valid_o     = w_rd_valid;
   assign rd_data_o      = w_rd_valid ? r_fifo_mem[r_rd_ptr] : '0;
   assign rd_last_o      = w_rd_valid & (r_ret_rem == LEN_W'(1));
   assign busy_o         = (r_state != S_IDLE);
   assign done_o         = (r_state == S_DONE);
   assign sram_addr_o    = r_addr;
   assign sram_wr_data_o = w_sram_wr_data;
   assign sram_en_o      = w_sram_en;
   assign sram_rw_mode_o = w_sram_rw;

endmodule

// File: tb/tb_sram_seq_ctrl.sv
// Directed bench for sram_seq_ctrl with a behavioural one-cycle-latency SRAM macro.
module tb_sram_seq_ctrl;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        cmd_valid_i = 1'b0;
   logic        cmd_ready_o;
   logic        cmd_write_i = 1'b0;
   logic [7:0]  cmd_addr_i = 8'd0;
   logic [8:0]  cmd_len_i = 9'd0;
   logic        wr_valid_i = 1'b0;
   logic        wr_ready_o;
   logic [63:0] wr_data_i = 64'd0;
   logic        rd_valid_o;
   logic        rd_ready_i = 1'b0;
   logic [63:0] rd_data_o;
   logic        rd_last_o;
   logic        busy_o;
   logic        done_o;
   logic [7:0]  sram_addr_o;
   logic [63:0] sram_wr_data_o;
   logic        sram_en_o;
   logic        sram_rw_mode_o;
   logic [63:0] sram_rd_data_i;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;

   always #5 clk_i = ~clk_i;

   sram_seq_ctrl dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
      .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
      .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o), .wr_data_i(wr_data_i),
      .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o), .rd_last_o(rd_last_o),
      .busy_o(busy_o), .done_o(done_o),
      .sram_addr_o(sram_addr_o), .sram_wr_data_o(sram_wr_data_o), .sram_en_o(sram_en_o),
      .sram_rw_mode_o(sram_rw_mode_o), .sram_rd_data_i(sram_rd_data_i)
   );

   // SRAM macro: write or registered read on enable
   logic [63:0] sram_mem [0:255];
   logic [63:0] sram_rd_q = 64'd0;
   always @(posedge clk_i) begin
      if (sram_en_o) begin
         if (sram_rw_mode_o) sram_mem[sram_addr_o] <= sram_wr_data_o;
         else                sram_rd_q <= sram_mem[sram_addr_o];
      end
   end
   assign sram_rd_data_i = sram_rd_q;

   always @(posedge clk_i) cyc <= cyc + 1;

   // Monitor log, sampled mid-cycle
   int          hs_cyc, first_valid_cyc, done_cnt, done_cyc, last_wr_cyc, os_cnt, max_os;
   logic [7:0]  wr_addr_q[$];
   logic [63:0] wr_data_q[$];
   logic [7:0]  rd_addr_q[$];
   logic [63:0] beat_q[$];
   logic        beat_last_q[$];
   int          beat_cyc_q[$];

   always @(negedge clk_i) begin
      if (!rst_i) begin
         os_cnt = 0;
      end else begin
         if (cmd_valid_i && cmd_ready_o) hs_cyc = cyc;
         if (rd_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (sram_en_o && sram_rw_mode_o) begin
            wr_addr_q.push_back(sram_addr_o);
            wr_data_q.push_back(sram_wr_data_o);
            last_wr_cyc = cyc;
         end
         if (os_cnt > max_os) max_os = os_cnt;
         if (sram_en_o && !sram_rw_mode_o) begin
            rd_addr_q.push_back(sram_addr_o);
            os_cnt++;
         end
         if (rd_valid_o && rd_ready_i) begin
            beat_q.push_back(rd_data_o);
            beat_last_q.push_back(rd_last_o);
            beat_cyc_q.push_back(cyc);
            os_cnt--;
         end
         if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
         end
      end
   end

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clear_log();
      wr_addr_q.delete(); wr_data_q.delete(); rd_addr_q.delete();
      beat_q.delete(); beat_last_q.delete(); beat_cyc_q.delete();
      hs_cyc = -100; first_valid_cyc = -1; done_cnt = 0; done_cyc = -100;
      last_wr_cyc = -100; max_os = 0;
   endtask

   task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [8:0] len);
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = a; cmd_len_i = len;
      @(posedge clk_i); #1;
      cmd_valid_i = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy_o && n < 60) begin
         @(posedge clk_i); #1;
         n++;
      end
      check_eq({tag, "_idle"}, 64'(busy_o), 64'd0);
   endtask

   task automatic check_read(input string tag, input logic [7:0] base, input logic [63:0] d0, input int len);
      check_eq({tag, "_beats"}, 64'(beat_q.size()), 64'(len));
      check_eq({tag, "_issues"}, 64'(rd_addr_q.size()), 64'(len));
      for (int i = 0; i < len && i < beat_q.size(); i++) begin
         check_eq({tag, "_data"}, beat_q[i], d0 + 64'(i));
         check_eq({tag, "_last"}, 64'(beat_last_q[i]), 64'(i == len - 1));
      end
      for (int i = 0; i < len && i < rd_addr_q.size(); i++)
         check_eq({tag, "_addr"}, 64'(rd_addr_q[i]), 64'(8'(base + 8'(i))));
      check_eq({tag, "_done_cnt"}, 64'(done_cnt), 64'd1);
      if (beat_cyc_q.size() == len)
         check_eq({tag, "_done_cyc"}, 64'(done_cyc), 64'(beat_cyc_q[len-1] + 1));
   endtask

   logic [3:0] pat = 4'b1001;

   initial begin
      clear_log();
      os_cnt = 0;
      // Reset state
      #1;
      check_eq("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
      check_eq("rst_busy", 64'(busy_o), 64'd0);
      repeat (2) @(posedge clk_i);
      #1 rst_i = 1'b1;
      #1;
      check_eq("idle_cmd_ready", 64'(cmd_ready_o), 64'd1);
      check_eq("idle_sram_en", 64'(sram_en_o), 64'd0);
      check_eq("idle_rd_valid", 64'(rd_valid_o), 64'd0);
      check_eq("idle_wr_ready", 64'(wr_ready_o), 64'd0);

      // Write 0x10 len 4 with a gap before every word
      clear_log();
      send_cmd(1'b1, 8'h10, 9'd4);
      check_eq("wr_ready_in_write", 64'(wr_ready_o), 64'd1);
      for (int i = 0; i < 4; i++) begin
         wr_valid_i = 1'b0;
         @(posedge clk_i); #1;
         wr_valid_i = 1'b1; wr_data_i = 64'hA0 + 64'(i);
         @(posedge clk_i); #1;
      end
      wr_valid_i = 1'b0;
      wait_idle("wr1");
      check_eq("wr1_count", 64'(wr_addr_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < wr_addr_q.size(); i++) begin
         check_eq("wr1_addr", 64'(wr_addr_q[i]), 64'(8'h10 + i));
         check_eq("wr1_data", wr_data_q[i], 64'hA0 + 64'(i));
      end
      check_eq("wr1_done_cnt", 64'(done_cnt), 64'd1);
      check_eq("wr1_done_cyc", 64'(done_cyc), 64'(last_wr_cyc + 1));

      // Read back at full rate
      clear_log();
      rd_ready_i = 1'b1;
      send_cmd(1'b0, 8'h10, 9'd4);
      wait_idle("rd1");
      check_eq("rd1_latency", 64'(first_valid_cyc - hs_cyc), 64'd3);
      check_read("rd1", 8'h10, 64'hA0, 4);
      if (beat_cyc_q.size() == 4)
         check_eq("rd1_back_to_back", 64'(beat_cyc_q[3] - beat_cyc_q[0]), 64'd3);

      // Read with backpressure pattern 1,0,0,1
      clear_log();
      rd_ready_i = 1'b0;
      send_cmd(1'b0, 8'h10, 9'd4);
      for (int k = 0; k < 60 && busy_o; k++) begin
         rd_ready_i = pat[k % 4];
         @(posedge clk_i); #1;
      end
      rd_ready_i = 1'b1;
      wait_idle("rd2");
      check_read("rd2", 8'h10, 64'hA0, 4);
      check_eq("rd2_outstanding_le2", 64'(max_os <= 2), 64'd1);

      // Address wrap: write then read 0xFE len 4
      clear_log();
      send_cmd(1'b1, 8'hFE, 9'd4);
      for (int i = 0; i < 4; i++) begin
         wr_valid_i = 1'b1; wr_data_i = 64'hC0DE_0000_0000_0000 + 64'(i);
         @(posedge clk_i); #1;
      end
      wr_valid_i = 1'b0;
      wait_idle("wr2");
      check_eq("wr2_count", 64'(wr_addr_q.size()), 64'd4);
      for (int i = 0; i < 4 && i < wr_addr_q.size(); i++)
         check_eq("wr2_addr", 64'(wr_addr_q[i]), 64'(8'(8'hFE + 8'(i))));
      clear_log();
      send_cmd(1'b0, 8'hFE, 9'd4);
      wait_idle("rd3");
      check_read("rd3", 8'hFE, 64'hC0DE_0000_0000_0000, 4);

      // Zero-length command
      clear_log();
      send_cmd(1'b0, 8'h20, 9'd0);
      check_eq("len0_done", 64'(done_o), 64'd1);
      check_eq("len0_cmd_ready_low", 64'(cmd_ready_o), 64'd0);
      @(posedge clk_i); #1;
      check_eq("len0_cmd_ready", 64'(cmd_ready_o), 64'd1);
      check_eq("len0_done_cyc", 64'(done_cyc - hs_cyc), 64'd1);
      check_eq("len0_done_cnt", 64'(done_cnt), 64'd1);
      check_eq("len0_no_sram", 64'(wr_addr_q.size() + rd_addr_q.size()), 64'd0);
      check_eq("len0_no_beats", 64'(beat_q.size()), 64'd0);

      // Reset mid-read after two beats
      clear_log();
      send_cmd(1'b0, 8'h10, 9'd4);
      for (int n = 0; n < 20 && beat_q.size() < 2; n++) begin
         @(posedge clk_i); #1;
      end
      check_eq("abort_two_beats", 64'(beat_q.size()), 64'd2);
      check_eq("abort_busy_before", 64'(busy_o), 64'd1);
      rst_i = 1'b0;
      #1;
      check_eq("abort_cmd_ready", 64'(cmd_ready_o), 64'd0);
      check_eq("abort_rd_valid", 64'(rd_valid_o), 64'd0);
      check_eq("abort_rd_data", rd_data_o, 64'd0);
      check_eq("abort_rd_last", 64'(rd_last_o), 64'd0);
      check_eq("abort_busy", 64'(busy_o), 64'd0);
      check_eq("abort_done", 64'(done_o), 64'd0);
      check_eq("abort_sram_en", 64'(sram_en_o), 64'd0);
      check_eq("abort_sram_addr", 64'(sram_addr_o), 64'd0);
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b1;
      repeat (2) @(posedge clk_i);
      #1;
      check_eq("abort_no_done", 64'(done_cnt), 64'd0);
      clear_log();
      send_cmd(1'b0, 8'h11, 9'd1);
      wait_idle("rd4");
      check_read("rd4", 8'h11, 64'hA1, 1);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
